truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Self-running exhaustive checker for an N_IN-input combinational lab circuit.
//  Drives every input vector 0..2**N_IN-1 to the DUT in ascending order, with vec[3]=G, vec[2]=T, vec[1]=U, vec[0]=E at N_IN=4.
//  Holds each vector for DWELL cycles and samples the DUT output y once per vector.
//  Builds the measured truth table, compares it with an expected table and reports pass/fail.
//  Sits between the board switches/LEDs wrapper and the circuit under test; it is the reading end of the stimulus sweep.
// PARAMETERS
//  N_IN      4   number of DUT inputs; table width TW = 2**N_IN
//  DWELL     10  cycles each vector is held; legal range >= 2
//  SAMPLE_AT 9   dwell-count value at which y is captured; legal range 1..DWELL-1
// PORTS
//  clk        in   1     single clock, rising edge
//  reset      in   1     synchronous, active-high
//  start      in   1     one-cycle or level pulse; begins a sweep when idle or done
//  y          in   1     DUT output
//  expected   in   TW    expected truth table, bit i = y for vector i; held stable through DONE
//  vec        out  N_IN  vector currently driven to the DUT
//  busy       out  1     sweep in progress
//  done       out  1     sweep complete; results valid
//  pass       out  1     done && (table_out == expected)
//  table_out  out  TW    measured table; bit i is captured while vec == i
//  fail_idx   out  N_IN  lowest index i with table_out[i] != expected[i]; 0 when pass
// BEHAVIOUR
//  Reset: state=IDLE. vec, cnt, table_out, busy, done, pass and fail_idx are all 0.
//   Reset applies from any state, including mid-sweep. A sweep interrupted by reset is discarded.
//  FSM states: IDLE, RUN, DONE.
//  IDLE -> RUN when start=1 at an edge. On that edge: vec<=0, cnt<=0, table_out<=0, busy<=1.
//  RUN:
//   - cnt counts 0..DWELL-1 and vec holds its value for exactly DWELL cycles.
//   - On the edge where cnt==SAMPLE_AT: table_out[vec] <= y.
//   - On the edge where cnt==DWELL-1 and vec < TW-1: vec<=vec+1, cnt<=0.
//   - On the edge where cnt==DWELL-1 and vec == TW-1: go to DONE; busy<=0, done<=1.
//     vec stays at TW-1 and does not wrap.
//   - start is ignored while in RUN.
//  Latency: done rises exactly TW*DWELL cycles after the start edge (160 at the defaults).
//   If SAMPLE_AT == DWELL-1, the last capture and the DONE transition share one edge.
//   pass must reflect that last captured bit in the first DONE cycle.
//  DONE: done=1 and all results hold until reset or start.
//   start in DONE behaves exactly like start in IDLE: table is cleared and a fresh sweep begins.
//  pass and fail_idx are combinational from table_out and expected, and are gated by done.
//   Outside DONE, both read 0.
//  Arithmetic: cnt is clog2(DWELL) bits wide and never exceeds DWELL-1. vec is N_IN bits wide.
//  Expected table for the reference lab function y=(G&T)|(U&E) is 16'hF888.
// TESTING
//  1 Assert reset for 2 cycles -> vec=0, busy=0, done=0, pass=0, table_out=16'h0000, fail_idx=0.
//  2 Model y=(G&T)|(U&E), expected=16'hF888, defaults, start pulse ->
//    vec steps every 10 cycles; done after 160 cycles; table_out=F888; pass=1.
//  3 Same model, expected=16'hF889 -> done=1, pass=0, fail_idx=0; table_out=F888.
//  4 start pulses at cycles 3 and 50 of a sweep -> no effect, done still at cycle 160.
//    Then start in DONE -> table_out=0, busy=1, and the second sweep also yields F888.
//  5 Assert reset during RUN while vec=5 -> next cycle IDLE with all outputs 0.
//    Then start -> sweep restarts at vec=0 and completes normally.
//  6 DWELL=2, SAMPLE_AT=1, y tied to 1 -> vec changes every 2 cycles;
//    done at cycle 32; table_out=FFFF; pass=1 with expected=FFFF.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives vec 0..TW-1, holds each for DWELL cycles, captures y at SAMPLE_AT.
// Sweep latency is TW*DWELL cycles from the start edge to done; start is ignored while a sweep runs.
module truth_table_sweeper #(
    parameter int N_IN      = 4,
    parameter int DWELL     = 10,
    parameter int SAMPLE_AT = 9,
    parameter int TW        = 2**N_IN
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            y_i,
    input  logic [TW-1:0]   expected_i,
    output logic [N_IN-1:0] vec_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [TW-1:0]   table_out_o,
    output logic [N_IN-1:0] fail_idx_o
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   SAMPLE_C = CW'(SAMPLE_AT);
    localparam logic [CW-1:0]   LAST_C   = CW'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   table_q;
    logic            busy_q;
    logic            done_q;
    logic [N_IN-1:0] first_diff;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        vec_q   <= '0;
                        cnt_q   <= '0;
                        table_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Capture and the final transition may share an edge; pass then sees the new bit.
                    if (cnt_q == SAMPLE_C) begin
                        table_q[vec_q] <= y_i;
                    end
                    if (cnt_q == LAST_C) begin
                        cnt_q <= '0;
                        if (vec_q == VEC_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            vec_q <= vec_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Scan from the top so the lowest mismatching index wins.
    always_comb begin
        first_diff = '0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (table_q[i] != expected_i[i]) begin
                first_diff = N_IN'(i);
            end
        end
    end

    assign vec_o       = vec_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign table_out_o = table_q;
    assign pass_o      = done_q && (table_q == expected_i);
    assign fail_idx_o  = done_q ? first_diff : '0;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: default sweeper against y=(G&T)|(U&E), plus a DWELL=2 instance with y tied high.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [15:0] exp_a, exp_b;
    logic        y_a;
    logic [3:0]  vec_a, vec_b, fidx_a, fidx_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] table_a, table_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign y_a = (vec_a[3] & vec_a[2]) | (vec_a[1] & vec_a[0]);

    truth_table_sweeper dut_a (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start_a),
        .y_i         (y_a),
        .expected_i  (exp_a),
        .vec_o       (vec_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .pass_o      (pass_a),
        .table_out_o (table_a),
        .fail_idx_o  (fidx_a)
    );

    truth_table_sweeper #(.N_IN(4), .DWELL(2), .SAMPLE_AT(1)) dut_b (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start_b),
        .y_i         (1'b1),
        .expected_i  (exp_b),
        .vec_o       (vec_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .pass_o      (pass_b),
        .table_out_o (table_b),
        .fail_idx_o  (fidx_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Counts cycles from the start edge to done; optionally pulses start mid-sweep.
    task automatic wait_done_a(input string tag, input bit inject);
        int n = 0;
        while (!done_a && n < 400) begin
            tick();
            n++;
            start_a = inject && (n == 3 || n == 50);
            if (n == 9)  check({tag, "_vec_at9"}, vec_a, 0);
            if (n == 10) check({tag, "_vec_at10"}, vec_a, 1);
            if (n == 80) check({tag, "_mid_flags"}, {busy_a, done_a, pass_a, fidx_a}, {1'b1, 1'b0, 1'b0, 4'd0});
        end
        start_a = 1'b0;
        check({tag, "_latency"}, n, 160);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        exp_a   = 16'hF888;
        exp_b   = 16'hFFFF;
        tick();
        tick();
        check("rst_vec", vec_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_table", table_a, 16'h0000);
        check("rst_fidx", fidx_a, 0);
        reset = 1'b0;

        // Matching expected table
        start_sweep_a();
        check("t2_start", {busy_a, done_a, vec_a, table_a}, {1'b1, 1'b0, 4'd0, 16'h0000});
        wait_done_a("t2", 1'b0);
        check("t2_table", table_a, 16'hF888);
        check("t2_pass", pass_a, 1);
        check("t2_busy_fidx_vec", {busy_a, fidx_a, vec_a}, {1'b0, 4'd0, 4'hF});
        repeat (5) tick();
        check("t2_hold", {done_a, pass_a, table_a}, {1'b1, 1'b1, 16'hF888});

        // Mismatch at bit 0
        exp_a = 16'hF889;
        start_sweep_a();
        wait_done_a("t3", 1'b0);
        check("t3_done_pass", {done_a, pass_a}, 2'b10);
        check("t3_fidx", fidx_a, 0);
        check("t3_table", table_a, 16'hF888);

        // Mismatch at bit 6
        exp_a = 16'hF8C8;
        start_sweep_a();
        wait_done_a("t3b", 1'b0);
        check("t3b_pass", pass_a, 0);
        check("t3b_fidx", fidx_a, 6);

        // start ignored in RUN, honoured in DONE
        exp_a = 16'hF888;
        start_sweep_a();
        wait_done_a("t4", 1'b1);
        check("t4_table", table_a, 16'hF888);
        start_sweep_a();
        check("t4_restart", {busy_a, done_a, pass_a, table_a}, {1'b1, 1'b0, 1'b0, 16'h0000});
        wait_done_a("t4b", 1'b0);
        check("t4b_result", {pass_a, table_a}, {1'b1, 16'hF888});

        // Reset mid-sweep
        start_sweep_a();
        repeat (55) tick();
        check("t5_vec_before", vec_a, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst", {vec_a, busy_a, done_a, pass_a, table_a, fidx_a}, 30'd0);
        tick();
        check("t5_idle", {vec_a, busy_a, done_a}, 6'd0);
        start_sweep_a();
        wait_done_a("t5", 1'b0);
        check("t5_result", {pass_a, table_a}, {1'b1, 16'hF888});

        // Short dwell instance
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 100) begin
            tick();
            n++;
            if (n == 1) check("t6_vec_at1", vec_b, 0);
            if (n == 2) check("t6_vec_at2", vec_b, 1);
            if (n == 7) check("t6_vec_at7", vec_b, 3);
        end
        check("t6_latency", n, 32);
        check("t6_table", table_b, 16'hFFFF);
        check("t6_pass", pass_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
